// File: rtl/gf2m_mac_seq_pkg.sv
// Shared constants and FSM encoding for the GF(2^m) inner-product sequencer.
// Defaults target the ROLLO field x^101 + x^7 + x^6 + x + 1.
package gf2m_mac_seq_pkg;

  localparam int FIELD_M    = 101;
  localparam int POLY_K3    = 7;
  localparam int POLY_K2    = 6;
  localparam int POLY_K1    = 1;
  localparam int DIGIT_D    = 16;
  localparam int TERM_CNT_W = 8;

  // The multiplier always processes one padding digit beyond WIDTH/D.
  function automatic int digit_count(input int width, input int d);
    return width / d + 1;
  endfunction

  localparam int DIGIT_N = digit_count(FIELD_M, DIGIT_D);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_OUT  = 2'd2
  } state_e;

endpackage

// File: rtl/gf2m_mac_seq_if.sv
// Operand-pair input stream and inner-product result stream of gf2m_mac_seq.
// Both sides transfer a beat on the rising edge where valid && ready; a source holds its payload stable while valid is high and ready is low.
interface gf2m_mac_seq_if #(
  parameter int WIDTH = gf2m_mac_seq_pkg::FIELD_M,
  parameter int CNT_W = gf2m_mac_seq_pkg::TERM_CNT_W
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_last;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_c;
  logic [CNT_W-1:0] out_terms;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_c, out_terms, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_c, out_terms, out_ovf
  );

endinterface

// File: rtl/gf2m_mul_ds.sv
// Digit-serial GF(2^m) multiplier, MSB digit first: one D-bit digit of b per cycle.
// start is sampled when idle; done pulses DIGIT_N+1 cycles after the start cycle with c_o valid.
module gf2m_mul_ds #(
  parameter int WIDTH = gf2m_mac_seq_pkg::FIELD_M,
  parameter int K3    = gf2m_mac_seq_pkg::POLY_K3,
  parameter int K2    = gf2m_mac_seq_pkg::POLY_K2,
  parameter int K1    = gf2m_mac_seq_pkg::POLY_K1,
  parameter int D     = gf2m_mac_seq_pkg::DIGIT_D
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] c_o,
  output logic             done_o
);
  import gf2m_mac_seq_pkg::*;

  localparam int NDIG = digit_count(WIDTH, D);
  localparam int PW   = NDIG * D;
  localparam int CW   = $clog2(NDIG + 1);
  localparam logic [WIDTH-1:0] RED = (WIDTH'(1) << K3) | (WIDTH'(1) << K2) |
                                     (WIDTH'(1) << K1) | WIDTH'(1);

  function automatic logic [WIDTH-1:0] xtime(input logic [WIDTH-1:0] v);
    return {v[WIDTH-2:0], 1'b0} ^ (v[WIDTH-1] ? RED : '0);
  endfunction

  // acc * x^D + a * digit, reduced one bit at a time (Horner order).
  function automatic logic [WIDTH-1:0] mac_digit(input logic [WIDTH-1:0] acc,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [D-1:0]     dig);
    logic [WIDTH-1:0] r;
    r = acc;
    for (int j = D - 1; j >= 0; j--) begin
      r = xtime(r);
      if (dig[j]) r = r ^ a;
    end
    return r;
  endfunction

  logic [WIDTH-1:0] a_q, a_d;
  logic [PW-1:0]    b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (busy_q) begin
      acc_d = mac_digit(acc_q, a_q, b_q[PW-1 -: D]);
      b_d   = b_q << D;
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end else if (start_i) begin
      a_d    = a_i;
      b_d    = {{(PW - WIDTH){1'b0}}, b_i};
      acc_d  = '0;
      cnt_d  = CW'(NDIG);
      busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign c_o    = acc_q;
  assign done_o = done_q;

endmodule

// File: rtl/gf2m_opnd_buf.sv
// One-entry operand buffer holding {a, b, last}; refills while the multiplier runs.
// full_d_o exposes the next-cycle fill state so the sequencer can register its start pulse.
module gf2m_opnd_buf #(
  parameter int WIDTH = gf2m_mac_seq_pkg::FIELD_M
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             last_i,
  output logic             full_o,
  output logic             full_d_o,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic             last_o
);
  import gf2m_mac_seq_pkg::*;

  logic             full_q, full_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             last_q, last_d;

  always_comb begin
    full_d = push_i | (full_q & ~pop_i);
    a_d    = a_q;
    b_d    = b_q;
    last_d = last_q;
    if (push_i) begin
      a_d    = a_i;
      b_d    = b_i;
      last_d = last_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      last_q <= 1'b0;
    end else begin
      full_q <= full_d;
      a_q    <= a_d;
      b_q    <= b_d;
      last_q <= last_d;
    end
  end

  assign full_o   = full_q;
  assign full_d_o = full_d;
  assign a_o      = a_q;
  assign b_o      = b_q;
  assign last_o   = last_q;

endmodule

// File: rtl/gf2m_mac_seq.sv
// Inner-product sequencer: feeds operand pairs to the digit-serial multiplier and
// XOR-accumulates products until the pair marked last, then presents the sum.
module gf2m_mac_seq #(
  parameter int WIDTH = gf2m_mac_seq_pkg::FIELD_M,
  parameter int K3    = gf2m_mac_seq_pkg::POLY_K3,
  parameter int K2    = gf2m_mac_seq_pkg::POLY_K2,
  parameter int K1    = gf2m_mac_seq_pkg::POLY_K1,
  parameter int D     = gf2m_mac_seq_pkg::DIGIT_D,
  parameter int CNT_W = gf2m_mac_seq_pkg::TERM_CNT_W
) (
  input  logic                      clk,
  input  logic                      rst,
  gf2m_mac_seq_if.slave             bus,
  output gf2m_mac_seq_pkg::state_e  dbg_state_o,
  output logic                      dbg_mul_start_o,
  output logic                      dbg_mul_done_o
);
  import gf2m_mac_seq_pkg::*;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] terms_q, terms_d;
  logic             ovf_q, ovf_d;
  logic             last_q, last_d;
  logic             start_q, start_d;
  logic             out_valid;

  logic             buf_push, buf_full, buf_full_d, buf_last;
  logic [WIDTH-1:0] buf_a, buf_b;
  logic [WIDTH-1:0] mul_c;
  logic             mul_done;
  logic             mul_rst_n;

  assign bus.in_ready = !buf_full && !rst;
  assign buf_push     = bus.in_valid && bus.in_ready;
  assign mul_rst_n    = ~rst;

  // The start pulse drains the buffer in the same cycle the multiplier latches it.
  gf2m_opnd_buf #(.WIDTH(WIDTH)) u_buf (
    .clk      (clk),
    .rst      (rst),
    .push_i   (buf_push),
    .pop_i    (start_q),
    .a_i      (bus.in_a),
    .b_i      (bus.in_b),
    .last_i   (bus.in_last),
    .full_o   (buf_full),
    .full_d_o (buf_full_d),
    .a_o      (buf_a),
    .b_o      (buf_b),
    .last_o   (buf_last)
  );

  gf2m_mul_ds #(.WIDTH(WIDTH), .K3(K3), .K2(K2), .K1(K1), .D(D)) u_mul (
    .clk     (clk),
    .rst_n   (mul_rst_n),
    .start_i (start_q),
    .a_i     (buf_a),
    .b_i     (buf_b),
    .c_o     (mul_c),
    .done_o  (mul_done)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    terms_d   = terms_q;
    ovf_d     = ovf_q;
    last_d    = last_q;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (buf_full) begin
          last_d  = buf_last;
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        if (mul_done) begin
          acc_d   = acc_q ^ mul_c;
          terms_d = terms_q + 1'b1;
          if (&terms_q) ovf_d = 1'b1;
          state_d = last_q ? S_OUT : S_IDLE;
        end
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (bus.out_ready) begin
          acc_d   = '0;
          terms_d = '0;
          ovf_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Registered equivalent of (state == IDLE && buffer full): one pulse per pair.
    start_d = (state_d == S_IDLE) && buf_full_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      terms_q <= '0;
      ovf_q   <= 1'b0;
      last_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      terms_q <= terms_d;
      ovf_q   <= ovf_d;
      last_q  <= last_d;
      start_q <= start_d;
    end
  end

  assign bus.out_valid = out_valid;
  assign bus.out_c     = acc_q;
  assign bus.out_terms = terms_q;
  assign bus.out_ovf   = ovf_q;

  assign dbg_state_o     = state_q;
  assign dbg_mul_start_o = start_q;
  assign dbg_mul_done_o  = mul_done;

endmodule

// File: tb/tb_gf2m_mac_seq.sv
// Directed bench for gf2m_mac_seq: latency, overlap, stall, counter wrap, reset abort
// and XOR accumulation, against a bit-serial GF(2^101) reference product.
module tb_gf2m_mac_seq;
  import gf2m_mac_seq_pkg::*;

  localparam int W  = 101;
  localparam int CW = 8;
  localparam logic [W-1:0] ONE = W'(1);

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  state_e dbg_state;
  logic   dbg_start;
  logic   dbg_done;

  gf2m_mac_seq_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  gf2m_mac_seq #(.WIDTH(W), .K3(7), .K2(6), .K1(1), .D(16), .CNT_W(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .dbg_state_o     (dbg_state),
    .dbg_mul_start_o (dbg_start),
    .dbg_mul_done_o  (dbg_done)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int start_log[$];
  int done_log[$];
  always @(negedge clk) begin
    if (dbg_start) start_log.push_back(cyc);
    if (dbg_done)  done_log.push_back(cyc);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: LSB-first shift-and-add modulo x^101 + x^7 + x^6 + x + 1.
  function automatic logic [W-1:0] mul_x(input logic [W-1:0] v);
    logic top;
    top = v[W-1];
    v = v << 1;
    if (top) begin
      v[7] = ~v[7];
      v[6] = ~v[6];
      v[1] = ~v[1];
      v[0] = ~v[0];
    end
    return v;
  endfunction

  function automatic logic [W-1:0] gf_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r, t;
    r = '0;
    t = a;
    for (int i = 0; i < W; i++) begin
      if (b[i]) r = r ^ t;
      t = mul_x(t);
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rand_el();
    logic [127:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    return r[W-1:0];
  endfunction

  // ---------------- driver tasks ----------------
  // Called and returning on a falling edge; t_acc is the cycle whose closing edge accepts.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic last,
                      output int t_acc, output state_e st);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_last  = last;
    while (!bus.in_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    t_acc = cyc;
    st    = dbg_state;
    if (!bus.in_ready) check("send_accept_timeout", bus.in_ready, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic collect(input string tag, input logic [CW-1:0] terms, input logic ovf,
                         output int t_seen);
    logic [W-1:0] exp_c;
    int n;
    n = 0;
    exp_c = exp_q.pop_front();
    while (!bus.out_valid && n < 4000) begin
      @(negedge clk);
      n++;
    end
    t_seen = cyc;
    check({tag, "_valid"}, bus.out_valid, 1);
    check({tag, "_c"}, bus.out_c, exp_c);
    check({tag, "_terms"}, bus.out_terms, terms);
    check({tag, "_ovf"}, bus.out_ovf, ovf);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int           t_a, t_b, t_s, spurious;
    state_e       st_a, st_b;
    logic [W-1:0] a, b, c, sum, x100, x200;

    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    // reset values
    repeat (3) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_c", bus.out_c, 0);
    check("rst_out_terms", bus.out_terms, 0);
    check("rst_out_ovf", bus.out_ovf, 0);
    check("rst_state", dbg_state, S_IDLE);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", bus.in_ready, 1);

    // single pair times ONE, latency from accept to out_valid
    a = rand_el();
    exp_q.push_back(a);
    send(a, ONE, 1'b1, t_a, st_a);
    collect("single", 1, 0, t_s);
    check("single_latency", t_s, t_a + 10);

    // two identical pairs back to back cancel; second accepted during first MUL
    a = rand_el();
    b = rand_el();
    start_log.delete();
    done_log.delete();
    exp_q.push_back('0);
    send(a, b, 1'b0, t_a, st_a);
    send(a, b, 1'b1, t_b, st_b);
    collect("pair2", 2, 0, t_s);
    check("pair2_accept_cycle", t_b, t_a + 2);
    check("pair2_accept_state", st_b, S_MUL);
    check("pair2_first_done", done_log[0], t_a + 9);
    check("pair2_restart_gap", start_log[1], done_log[0] + 1);
    check("pair2_latency", t_s, t_a + 19);

    // hand-reduced vectors: x * x^100 = x^7+x^6+x+1, plus x^100 * 1
    x100 = '0;
    x100[100] = 1'b1;
    exp_q.push_back(W'(101'hC3));
    send(W'(2), x100, 1'b1, t_a, st_a);
    collect("xred", 1, 0, t_s);
    exp_q.push_back(x100 | W'(101'hC3));
    send(W'(2), x100, 1'b0, t_a, st_a);
    send(x100, ONE, 1'b1, t_a, st_a);
    collect("xred2", 2, 0, t_s);

    // 32 random pairs with gaps, then output stalled with next-sum pair queued
    sum = '0;
    for (int i = 0; i < 32; i++) begin
      a = rand_el();
      b = rand_el();
      sum = sum ^ gf_mul(a, b);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(a, b, (i == 31), t_a, st_a);
    end
    for (int n = 0; n < 200 && !bus.out_valid; n++) @(negedge clk);
    check("rand32_valid", bus.out_valid, 1);
    c = rand_el();
    send(c, ONE, 1'b1, t_a, st_a);
    for (int i = 0; i < 20; i++) begin
      check("rand32_stall_c", bus.out_c, sum);
      check("rand32_stall_start", dbg_start, 0);
      @(negedge clk);
    end
    check("rand32_stall_state", dbg_state, S_OUT);
    check("rand32_queued_ready", bus.in_ready, 0);
    exp_q.push_back(sum);
    collect("rand32", 32, 0, t_s);
    exp_q.push_back(c);
    collect("rand32_next", 1, 0, t_s);

    // 256 pairs wrap the term counter and set the sticky overflow
    sum = '0;
    for (int i = 0; i < 256; i++) begin
      a = rand_el();
      b = rand_el();
      sum = sum ^ gf_mul(a, b);
      send(a, b, (i == 255), t_a, st_a);
    end
    exp_q.push_back(sum);
    collect("wrap256", 0, 1, t_s);
    a = rand_el();
    exp_q.push_back(a);
    send(a, ONE, 1'b1, t_a, st_a);
    collect("wrap_next", 1, 0, t_s);

    // reset in the middle of a multiplication
    send(rand_el(), rand_el(), 1'b1, t_a, st_a);
    repeat (3) @(negedge clk);
    check("abort_pre_state", dbg_state, S_MUL);
    rst = 1'b1;
    #1;
    check("abort_async_state", dbg_state, S_IDLE);
    repeat (2) @(negedge clk);
    check("abort_in_ready", bus.in_ready, 0);
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_out_c", bus.out_c, 0);
    check("abort_out_terms", bus.out_terms, 0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_release_ready", bus.in_ready, 1);
    spurious = 0;
    for (int i = 0; i < 15; i++) begin
      if (bus.out_valid || dbg_start) spurious++;
      @(negedge clk);
    end
    check("abort_spurious", spurious, 0);
    // x^200 mod f = x^100 + x^99 + x^12 + x^10 + x^6 + x^4
    x200 = '0;
    x200[100] = 1'b1;
    x200[99]  = 1'b1;
    x200[12]  = 1'b1;
    x200[10]  = 1'b1;
    x200[6]   = 1'b1;
    x200[4]   = 1'b1;
    exp_q.push_back(x200);
    send(x100, x100, 1'b1, t_a, st_a);
    collect("abort_square", 1, 0, t_s);

    // XOR accumulation: A + B + (A^B) = 0
    a = rand_el();
    b = rand_el();
    exp_q.push_back('0);
    send(a, ONE, 1'b0, t_a, st_a);
    send(b, ONE, 1'b0, t_a, st_a);
    send(a ^ b, ONE, 1'b1, t_a, st_a);
    collect("xor3", 3, 0, t_s);

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
